univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_pkg.sv | 28 ++
 rtl/sat_counter.sv | 31 +++
 rtl/univ_shift_reg.sv | 107 ++++++++++
 tb/tb_univ_shift_reg.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// ---------------------------------------------------------------------------
// univ_shift_pkg
//   Shared definitions for the universal shift register: the operation
//   encoding used on the 3-bit mode port, plus a helper that marks
//   which operations count as shifts.
// ---------------------------------------------------------------------------
package univ_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7   // treated exactly like HOLD
    } univ_shift_mode_e;

    // True for every operation that moves a bit out of the register and
    // therefore advances the shift counter.
    function automatic logic is_shift(input univ_shift_mode_e m);
        return (m == MODE_SHL)  || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR) ||
               (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at MAX instead of wrapping.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous active-high reset, clears cnt
//     clr   - synchronous clear (wins over inc)
//     inc   - increment by one unless already at MAX
//     cnt   - current count, $clog2(MAX+1) bits
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter  int MAX = 8,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != W'(MAX)))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
//   WIDTH-bit universal shift register: hold, parallel load, logical shift
//   left/right, rotate left/right and arithmetic shift right, with a
//   registered shift-out bit and a saturating count of shifts since the
//   last load.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous active-high reset (q=RESET_VAL, sout=0, cnt=0)
//     en    - operation enable; low means hold
//     mode  - operation select (univ_shift_mode_e)
//     sin   - serial input for SHL/SHR
//     d     - parallel load data
//     q     - register contents
//     qb    - ~q
//     sout  - bit shifted/rotated out by the last shift op
//     cnt   - shifts since last load, saturating at WIDTH
//     done  - cnt == WIDTH
// ---------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    univ_shift_mode_e op;
    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic             cnt_clr;
    logic             cnt_inc;

    assign op = univ_shift_mode_e'(mode);

    // Next-state mux for q and sout. With en low every input other than
    // the current state is ignored, so d/sin/mode cannot reach outputs.
    always_comb begin
        q_nxt    = q;
        sout_nxt = sout;
        if (en) begin
            case (op)
                MODE_LOAD: q_nxt = d;
                MODE_SHL: begin
                    q_nxt    = {q[WIDTH-2:0], sin};
                    sout_nxt = q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_nxt    = {sin, q[WIDTH-1:1]};
                    sout_nxt = q[0];
                end
                MODE_ROTL: begin
                    q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                    sout_nxt = q[WIDTH-1];
                end
                MODE_ROTR: begin
                    q_nxt    = {q[0], q[WIDTH-1:1]};
                    sout_nxt = q[0];
                end
                MODE_ASR: begin
                    q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
                    sout_nxt = q[0];
                end
                default: ;  // HOLD and reserved code keep state
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= RESET_VAL;
            sout <= 1'b0;
        end else begin
            q    <= q_nxt;
            sout <= sout_nxt;
        end
    end

    assign cnt_clr = en && (op == MODE_LOAD);
    assign cnt_inc = en && is_shift(op);

    sat_counter #(
        .MAX (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt)
    );

    assign qb   = ~q;
    assign done = (cnt == CW'(WIDTH));

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
    import univ_shift_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset, reset2;
    logic          en;
    logic [2:0]    mode;
    logic          sin;
    logic [W-1:0]  d;
    logic [W-1:0]  q, qb, q2, qb2;
    logic          sout, sout2, done, done2;
    logic [CW-1:0] cnt, cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .d(d),
        .q(q), .qb(qb), .sout(sout), .cnt(cnt), .done(done)
    );

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h3C)) dut2 (
        .clk(clk), .reset(reset2), .en(en), .mode(mode), .sin(sin), .d(d),
        .q(q2), .qb(qb2), .sout(sout2), .cnt(cnt2), .done(done2)
    );

    // Apply one operation at the falling edge, sample 1ns after the rise.
    task automatic drive(input logic [2:0] m, input logic [W-1:0] dv,
                         input logic s, input logic e);
        @(negedge clk);
        mode = m; d = dv; sin = s; en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        // Reset asserted from time 0; sampled before any rising edge.
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_q: got %h exp 00", q); end
        checks++; if (qb !== 8'hFF) begin errors++; $display("FAIL rst_qb: got %h exp FF", qb); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL rst_sout: got %b exp 0", sout); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", done); end
        checks++; if (q2 !== 8'h3C) begin errors++; $display("FAIL rst_q2: got %h exp 3C", q2); end
        checks++; if (qb2 !== 8'hC3) begin errors++; $display("FAIL rst_qb2: got %h exp C3", qb2); end
        @(negedge clk);
        reset = 1'b0; reset2 = 1'b0;
    endtask

    task automatic test_shift;
        drive(MODE_LOAD, 8'hA5, 1'b0, 1'b1);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q: got %h exp A5", q); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL load_cnt: got %0d exp 0", cnt); end
        drive(MODE_SHL, 8'h00, 1'b1, 1'b1);
        checks++; if (q !== 8'h4B) begin errors++; $display("FAIL shl_q: got %h exp 4B", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL shl_sout: got %b exp 1", sout); end
        checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL shl_cnt: got %0d exp 1", cnt); end
        drive(MODE_SHR, 8'h00, 1'b0, 1'b1);
        checks++; if (q !== 8'h25) begin errors++; $display("FAIL shr_q: got %h exp 25", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL shr_sout: got %b exp 1", sout); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL shr_cnt: got %0d exp 2", cnt); end
        checks++; if (qb !== 8'hDA) begin errors++; $display("FAIL shr_qb: got %h exp DA", qb); end
    endtask

    task automatic test_rotate;
        drive(MODE_LOAD, 8'h81, 1'b0, 1'b1);
        drive(MODE_ROTL, 8'h00, 1'b0, 1'b1);
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL rotl_q: got %h exp 03", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL rotl_sout: got %b exp 1", sout); end
        drive(MODE_LOAD, 8'h81, 1'b0, 1'b1);
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reload_cnt: got %0d exp 0", cnt); end
        for (int i = 0; i < 7; i++) drive(MODE_ROTR, 8'h00, 1'b0, 1'b1);
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL rotr7_q: got %h exp 03", q); end
        checks++; if (cnt !== 4'd7) begin errors++; $display("FAIL rotr7_cnt: got %0d exp 7", cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rotr7_done: got %b exp 0", done); end
        drive(MODE_ROTR, 8'h00, 1'b0, 1'b1);
        checks++; if (q !== 8'h81) begin errors++; $display("FAIL rotr8_q: got %h exp 81", q); end
        checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL rotr8_cnt: got %0d exp 8", cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rotr8_done: got %b exp 1", done); end
        drive(MODE_ROTR, 8'h00, 1'b1, 1'b1);
        checks++; if (q !== 8'hC0) begin errors++; $display("FAIL rotr9_q: got %h exp C0", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL rotr9_sout: got %b exp 1", sout); end
        checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL rotr9_cnt: got %0d exp 8", cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rotr9_done: got %b exp 1", done); end
    endtask

    task automatic test_asr;
        drive(MODE_LOAD, 8'h80, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(MODE_ASR, 8'h00, 1'b1, 1'b1);
        checks++; if (q !== 8'hF0) begin errors++; $display("FAIL asr_q: got %h exp F0", q); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL asr_sout: got %b exp 0", sout); end
        checks++; if (cnt !== 4'd3) begin errors++; $display("FAIL asr_cnt: got %0d exp 3", cnt); end
    endtask

    task automatic test_hold;
        drive(MODE_LOAD, 8'hA5, 1'b0, 1'b1);
        drive(MODE_SHL, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(MODE_LOAD, 8'h3C, 1'b1, 1'b0);
        checks++; if (q !== 8'h4B) begin errors++; $display("FAIL en0_q: got %h exp 4B", q); end
        checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL en0_cnt: got %0d exp 1", cnt); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL en0_sout: got %b exp 1", sout); end
        for (int i = 0; i < 2; i++) drive(3'd7, 8'h3C, 1'b0, 1'b1);
        checks++; if (q !== 8'h4B) begin errors++; $display("FAIL rsvd_q: got %h exp 4B", q); end
        checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL rsvd_cnt: got %0d exp 1", cnt); end
        drive(MODE_HOLD, 8'h3C, 1'b0, 1'b1);
        checks++; if (q !== 8'h4B) begin errors++; $display("FAIL hold_q: got %h exp 4B", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL hold_sout: got %b exp 1", sout); end
    endtask

    task automatic test_async_reset;
        drive(MODE_LOAD, 8'hAD, 1'b0, 1'b1);
        drive(MODE_SHL, 8'h00, 1'b0, 1'b1);
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL pre_rst_q: got %h exp 5A", q); end
        checks++; if (sout !== 1'b1) begin errors++; $display("FAIL pre_rst_sout: got %b exp 1", sout); end
        // Assert between edges and look before the next rising edge.
        #2 reset = 1'b1;
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_rst_q: got %h exp 00", q); end
        checks++; if (qb !== 8'hFF) begin errors++; $display("FAIL mid_rst_qb: got %h exp FF", qb); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d exp 0", cnt); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL mid_rst_sout: got %b exp 0", sout); end
        // Reset still high across an edge with LOAD requested: reset wins.
        drive(MODE_LOAD, 8'hFF, 1'b1, 1'b1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_prio_q: got %h exp 00", q); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL post_rst_q: got %h exp FF", q); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL post_rst_cnt: got %0d exp 0", cnt); end
    endtask

    task automatic test_reset_val;
        // dut2 has been following the same loads; it now holds FF.
        checks++; if (q2 !== 8'hFF) begin errors++; $display("FAIL rv_pre_q: got %h exp FF", q2); end
        #2 reset2 = 1'b1;
        #1;
        checks++; if (q2 !== 8'h3C) begin errors++; $display("FAIL rv_q: got %h exp 3C", q2); end
        checks++; if (qb2 !== 8'hC3) begin errors++; $display("FAIL rv_qb: got %h exp C3", qb2); end
        checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL rv_cnt: got %0d exp 0", cnt2); end
        @(negedge clk);
        reset2 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        en = 1'b0; mode = MODE_HOLD; sin = 1'b0; d = '0;
        test_reset();
        test_shift();
        test_rotate();
        test_asr();
        test_hold();
        test_async_reset();
        test_reset_val();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
